// File: rtl/seq_divider_32by16_if.sv
// Operand/result handshake bundle for the 32-by-16 sequential divider.
// The master side presents operands and accepts results; the slave side is the divider.
`timescale 1ns/1ps
interface seq_divider_32by16_if #(
  parameter int DW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_32by16.sv
// Radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Zero-divisor and quotient-overflow cases are resolved at acceptance and skip the iteration.
`timescale 1ns/1ps
module seq_divider_32by16 #(
  parameter int DW = 16,
  parameter int CW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_divider_32by16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg,   cnt_next;
  // Partial remainder is always below the divisor, so its DW+1'th bit is implicitly 0.
  logic [DW-1:0]   r_reg,     r_next;
  logic [DW-1:0]   q_reg,     q_next;
  logic [DW-1:0]   div_reg,   div_next;
  logic [DW-1:0]   quot_reg,  quot_next;
  logic [DW-1:0]   rem_reg,   rem_next;
  logic            dbz_reg,   dbz_next;
  logic            ovf_reg,   ovf_next;

  logic [DW:0]     trial;
  logic [DW:0]     trial_diff;
  logic            trial_ge;
  logic [DW-1:0]   r_iter;
  logic [DW-1:0]   q_iter;
  logic [DW-1:0]   dividend_hi;
  logic [DW-1:0]   dividend_lo;

  assign dividend_hi = bus.dividend[2*DW-1:DW];
  assign dividend_lo = bus.dividend[DW-1:0];

  // One restoring step: shift the next dividend bit into the remainder and try a subtract.
  always_comb begin
    trial      = {r_reg, q_reg[DW-1]};
    trial_diff = trial - {1'b0, div_reg};
    trial_ge   = (trial >= {1'b0, div_reg});
    r_iter     = trial_ge ? trial_diff[DW-1:0] : trial[DW-1:0];
    q_iter     = {q_reg[DW-2:0], trial_ge};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    div_next   = div_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            state_next = DONE;
            quot_next  = '1;
            rem_next   = dividend_lo;
            dbz_next   = 1'b1;
            ovf_next   = 1'b0;
          end else if (dividend_hi >= bus.divisor) begin
            // Quotient would need more than DW bits.
            state_next = DONE;
            quot_next  = '1;
            rem_next   = '0;
            dbz_next   = 1'b0;
            ovf_next   = 1'b1;
          end else begin
            state_next = CALC;
            r_next     = dividend_hi;
            q_next     = dividend_lo;
            div_next   = bus.divisor;
            cnt_next   = '0;
            dbz_next   = 1'b0;
            ovf_next   = 1'b0;
          end
        end
      end
      CALC: begin
        r_next   = r_iter;
        q_next   = q_iter;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ITER) begin
          state_next = DONE;
          quot_next  = q_iter;
          rem_next   = r_iter;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      div_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      r_reg     <= r_next;
      q_reg     <= q_next;
      div_reg   <= div_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

endmodule
